chacha20_block_engine: RTL and testbench

Iterative ChaCha20 block function built around four combinational QR instances.
- Loads key, nonce and counter into the 16-word state matrix.
- Executes one full round (column or diagonal, four QRs in parallel) per clock.
- Adds the original input state, then presents the 512-bit keystream block.
- Sits between the cipher top-level controller (supplies key/nonce/counter) and the XOR/keystream buffer stage (consumes blocks).

---
 rtl/chacha20_block_engine.sv | 135 +++++++++++++
 tb/tb_chacha20_block_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_block_engine.sv
// Iterative ChaCha20 block function: one column or diagonal round per clock.
// Optional CHACHA20_ZEROIZE_EN clears all key-derived state after each block is consumed.
module chacha20_block_engine #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    localparam int RW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  rnd_q;
    logic [31:0]    init_q  [16];
    logic [31:0]    work_q  [16];
    logic [31:0]    init_w  [16];
    logic [31:0]    round_w [16];
    logic [511:0]   ks_q;
    logic           accept, hshake, last_rnd;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    always_comb begin
        init_w[0] = 32'h61707865;
        init_w[1] = 32'h3320646e;
        init_w[2] = 32'h79622d32;
        init_w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) init_w[4+i] = key[32*i +: 32];
        init_w[12] = counter;
        for (int i = 0; i < 3; i++) init_w[13+i] = nonce[32*i +: 32];
    end

    // Odd rounds rotate the b/c/d rows by 1/2/3 lanes to form the diagonals.
    always_comb begin
        logic [1:0] qq;
        logic [3:0] ia, ib, ic, id;
        logic       odd;
        round_w = work_q;
        odd = rnd_q[0];
        for (int q = 0; q < 4; q++) begin
            qq = 2'(q);
            ia = {2'b00, qq};
            ib = {2'b01, qq + {1'b0, odd}};
            ic = {2'b10, qq + {odd, 1'b0}};
            id = {2'b11, qq + {odd, odd}};
            {round_w[ia], round_w[ib], round_w[ic], round_w[id]} =
                qr(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
        end
    end

    assign last_rnd = (rnd_q == RW'(ROUNDS - 1));
    assign accept   = in_valid && (state_q == IDLE);
    assign hshake   = out_ready && (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_rnd) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= '0;
            ks_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                init_q[i] <= '0;
                work_q[i] <= '0;
            end
        end else if (accept) begin
            rnd_q  <= '0;
            init_q <= init_w;
            work_q <= init_w;
        end else if (state_q == ROUND) begin
            rnd_q  <= rnd_q + 1'b1;
            work_q <= round_w;
            if (last_rnd) begin
                for (int i = 0; i < 16; i++)
                    ks_q[32*i +: 32] <= round_w[i] + init_q[i];
            end
`ifdef CHACHA20_ZEROIZE_EN
        end else if (hshake) begin
            ks_q <= '0;
            for (int i = 0; i < 16; i++) begin
                init_q[i] <= '0;
                work_q[i] <= '0;
            end
`endif
        end
    end

    assign keystream = ks_q;

endmodule

// File: tb/tb_chacha20_block_engine.sv
// Self-checking bench for chacha20_block_engine (20-round and 8-round builds).
// Expected blocks come from an RFC-style reference block function.
module tb_chacha20_block_engine;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic [511:0] keystream;

    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [511:0] keystream8;

    int ntests = 0;
    int nfail  = 0;

    chacha20_block_engine #(.ROUNDS(20)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .nonce(nonce), .counter(counter),
        .out_valid(out_valid), .out_ready(out_ready),
        .keystream(keystream), .busy(busy)
    );

    chacha20_block_engine #(.ROUNDS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .key(key), .nonce(nonce), .counter(counter),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .keystream(keystream8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] mqr(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = rl(d, 16);
        c += d; b ^= c; b = rl(b, 12);
        a += b; d ^= a; d = rl(d, 8);
        c += d; b ^= c; b = rl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                           input logic [31:0] c, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int r2 = 0; r2 < rounds / 2; r2++) begin
            {x[0], x[4], x[8],  x[12]} = mqr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = mqr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = mqr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = mqr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = mqr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = mqr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = mqr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = mqr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one request and wait for out_valid; leaves the block pending in DONE.
    task automatic start_block(input string tag, input logic [255:0] k,
                               input logic [95:0] n, input logic [31:0] c,
                               output logic [511:0] ks);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        check({tag, " in_ready"}, in_ready, 1);
        key = k; nonce = n; counter = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        key = ~k; nonce = ~n; counter = ~c;
        check({tag, " busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, lat, 20);
        ks = keystream;
        check({tag, " block"}, ks, model(k, n, c, 20));
    endtask

    task automatic finish_block(input string tag, input logic [511:0] ks);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " ov_drop"}, out_valid, 0);
        check({tag, " ready_back"}, in_ready, 1);
`ifdef CHACHA20_ZEROIZE_EN
        check({tag, " zeroize"}, keystream, 512'd0);
`else
        check({tag, " ks_kept"}, keystream, ks);
`endif
    endtask

    logic [255:0] kat_key, rk;
    logic [95:0]  kat_nonce, rn;
    logic [31:0]  rc;
    logic [511:0] ks, ks_hold;
    int           lat8;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        key = '0; nonce = '0; counter = '0;
        for (int i = 0; i < 32; i++) kat_key[8*i +: 8] = 8'(i);
        kat_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst keystream", keystream, 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_block("kat", kat_key, kat_nonce, 32'd1, ks);
        check("kat w0", ks[31:0], 32'he4e7f110);
        check("kat w1", ks[63:32], 32'h15593bd1);
        check("kat w15", ks[511:480], 32'h4e3c50a2);
        finish_block("kat", ks);

        start_block("zero", '0, '0, '0, ks);
        check("zero w0", ks[31:0], 32'hade0b876);
        check("zero w1", ks[63:32], 32'h903df1a0);
        finish_block("zero", ks);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
            for (int i = 0; i < 3; i++) rn[32*i +: 32] = $urandom;
            rc = $urandom;
            start_block("rand", rk, rn, rc, ks);
            finish_block("rand", ks);
        end

        // Backpressure with in_valid pulses that must be ignored
        start_block("bp", kat_key, kat_nonce, 32'd7, ks);
        ks_hold = ks;
        for (int i = 0; i < 15; i++) begin
            in_valid = i[0];
            @(posedge clk); #1;
            check("bp stable", keystream, ks_hold);
            check("bp in_ready", in_ready, 0);
            check("bp out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        finish_block("bp", ks_hold);
        check("bp not_busy", busy, 0);

        // Reset while round 7 is being applied
        key = kat_key; nonce = kat_nonce; counter = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid in_ready", in_ready, 1);
        check("mid out_valid", out_valid, 0);
        check("mid busy", busy, 0);
        check("mid keystream", keystream, 512'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_block("postrst", kat_key, kat_nonce, 32'd1, ks);
        check("postrst w0", ks[31:0], 32'he4e7f110);
        finish_block("postrst", ks);

        // Reduced-round instance
        check("r8 in_ready", in_ready8, 1);
        key = kat_key; nonce = kat_nonce; counter = 32'd1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat8 = 0;
        while (!out_valid8 && lat8 < 100) begin @(posedge clk); #1; lat8++; end
        check("r8 latency", lat8, 8);
        check("r8 block", keystream8, model(kat_key, kat_nonce, 32'd1, 8));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("r8 ov_drop", out_valid8, 0);
        check("r8 ready_back", in_ready8, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
